mac_column_sequencer: RTL and testbench

- Control stage directly upstream of the bit-column MAC unit.
- Accepts one tile command (`start`, column count, pooling flag) and streams per-column control descriptors into the MAC through a valid/ready handshake.
- Drives the MAC's enable, load-accumulate, column index and MSB flags, aligned to the MAC's one-stage psum pipeline plus accumulator.
- Captures the finished 16-bit MAC result and returns it on a valid/ready output port.

---
 rtl/mac_column_sequencer_if.sv | 44 ++++
 rtl/mac_column_sequencer.sv | 109 ++++++++++
 tb/tb_mac_column_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mac_column_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | mac_column_sequencer_if                                                    |
// | Column-descriptor stream, MAC control bus and result port of the sequencer.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mac_column_sequencer_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int CTRL_WIDTH    = 44,
    parameter int COL_IDX_WIDTH = 3
);
    logic                       col_valid;
    logic                       col_ready;
    logic [CTRL_WIDTH-1:0]      col_desc;

    logic                       mac_en;
    logic                       mac_load_accum;
    logic [CTRL_WIDTH-1:0]      mac_ctrl;
    logic [COL_IDX_WIDTH-1:0]   mac_column_idx;
    logic                       mac_is_msb;
    logic                       mac_is_pooling;
    logic [2*DATA_WIDTH-1:0]    mac_result;

    logic                       res_valid;
    logic                       res_ready;
    logic [2*DATA_WIDTH-1:0]    res_data;

    // Sequencer side
    modport slave (
        input  col_valid, col_desc, mac_result, res_ready,
        output col_ready, mac_en, mac_load_accum, mac_ctrl, mac_column_idx,
               mac_is_msb, mac_is_pooling, res_valid, res_data
    );

    // Descriptor source / MAC / result consumer side
    modport master (
        output col_valid, col_desc, mac_result, res_ready,
        input  col_ready, mac_en, mac_load_accum, mac_ctrl, mac_column_idx,
               mac_is_msb, mac_is_pooling, res_valid, res_data
    );
endinterface

`default_nettype wire

// File: rtl/mac_column_sequencer.sv
// +----------------------------------------------------------------------------+
// | mac_column_sequencer                                                       |
// | Streams per-column descriptors into the bit-column MAC and captures result.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mac_column_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_COLS      = 8,
    parameter int COL_IDX_WIDTH = 3,
    parameter int CTRL_WIDTH    = 44
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                start,
    input  wire logic [3:0]          num_cols,
    input  wire logic                is_pooling_in,
    output logic                     busy,
    mac_column_sequencer_if.slave    bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]                 r_state;
    logic [COL_IDX_WIDTH-1:0]   r_col_cnt;
    logic [COL_IDX_WIDTH-1:0]   r_msb_idx;
    logic [1:0]                 r_en_cnt;
    logic                       r_pool;
    logic [2*DATA_WIDTH-1:0]    r_res_data;

    logic                       w_xfer;
    logic                       w_mac_en;
    logic [COL_IDX_WIDTH-1:0]   w_eff_last;

    // Out-of-range column counts fall back to a full tile
    assign w_eff_last = (num_cols == 4'd0 || num_cols > 4'(MAX_COLS))
                      ? COL_IDX_WIDTH'(MAX_COLS - 1)
                      : COL_IDX_WIDTH'(num_cols - 4'd1);

    assign w_xfer   = (r_state == S_RUN) && bus.col_valid;
    assign w_mac_en = w_xfer || (r_state == S_DRAIN);

    assign bus.col_ready      = (r_state == S_RUN);
    assign bus.mac_en         = w_mac_en;
    assign bus.mac_ctrl       = w_xfer ? bus.col_desc : '0;
    assign bus.mac_column_idx = w_xfer ? r_col_cnt : '0;
    assign bus.mac_is_msb     = w_xfer && (r_col_cnt == r_msb_idx);
    // The first enable adds a stale psum; the second one reloads the accumulator
    assign bus.mac_load_accum = w_mac_en && (r_en_cnt == 2'd1);
    assign bus.mac_is_pooling = (r_state != S_IDLE) && r_pool;
    assign bus.res_valid      = (r_state == S_DONE);
    assign bus.res_data       = r_res_data;
    assign busy               = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_col_cnt  <= '0;
            r_msb_idx  <= '0;
            r_en_cnt   <= 2'd0;
            r_pool     <= 1'b0;
            r_res_data <= '0;
        end else begin
            if (w_mac_en && r_en_cnt != 2'd2) begin
                r_en_cnt <= r_en_cnt + 2'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_msb_idx <= w_eff_last;
                        r_col_cnt <= w_eff_last;
                        r_en_cnt  <= 2'd0;
                        r_pool    <= is_pooling_in;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_col_cnt <= r_col_cnt - 1'b1;
                        if (r_col_cnt == '0) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_res_data <= bus.mac_result;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mac_column_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_mac_column_sequencer                                                    |
// | Directed tile scenarios against a cycle-by-cycle tile model.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mac_column_sequencer;
    localparam int DW = 8;
    localparam int CW = 44;
    localparam int IW = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] num_cols;
    logic       is_pooling_in;
    logic       busy;

    always #5 clk = ~clk;

    mac_column_sequencer_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .COL_IDX_WIDTH(IW)) bus ();

    mac_column_sequencer #(
        .DATA_WIDTH(DW), .MAX_COLS(8), .COL_IDX_WIDTH(IW), .CTRL_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_cols(num_cols),
        .is_pooling_in(is_pooling_in), .busy(busy), .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs for the current cycle
    logic          chk_en = 1'b0;
    logic          e_col_ready, e_en, e_ld, e_msb, e_pool, e_rv, e_busy;
    logic [CW-1:0] e_ctrl;
    logic [IW-1:0] e_idx;
    logic [15:0]   e_rd;
    logic [15:0]   last_res = 16'd0;
    int            tile_cyc = 0;
    int            first_rv = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t (tile cycle %0d): got %0h, expected %0h",
                     nm, $time, tile_cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("col_ready",      64'(bus.col_ready),      64'(e_col_ready));
            chk("mac_en",         64'(bus.mac_en),         64'(e_en));
            chk("mac_load_accum", 64'(bus.mac_load_accum), 64'(e_ld));
            chk("mac_ctrl",       64'(bus.mac_ctrl),       64'(e_ctrl));
            chk("mac_column_idx", 64'(bus.mac_column_idx), 64'(e_idx));
            chk("mac_is_msb",     64'(bus.mac_is_msb),     64'(e_msb));
            chk("mac_is_pooling", 64'(bus.mac_is_pooling), 64'(e_pool));
            chk("res_valid",      64'(bus.res_valid),      64'(e_rv));
            chk("res_data",       64'(bus.res_data),       64'(e_rd));
            chk("busy",           64'(busy),               64'(e_busy));
            if (bus.res_valid === 1'b1 && first_rv < 0) first_rv = tile_cyc;
        end
    end

    function automatic logic [CW-1:0] rdesc();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[CW-1:0];
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_col_ready = 1'b0; e_en = 1'b0; e_ld = 1'b0; e_ctrl = '0; e_idx = '0;
        e_msb = 1'b0; e_pool = 1'b0; e_rv = 1'b0; e_busy = 1'b0; e_rd = last_res;
    endtask

    // One tile: gap = idle col_valid cycles after the first transfer,
    // hold = DONE cycles with res_ready low, exp_lat = start-to-res_valid cycles.
    task automatic run_tile(input int ncmd, input bit pool, input int gap, input int hold,
                            input bit start_in_done, input int exp_lat);
        int eff, k, en_seen, gap_left, c;
        logic v;
        logic [15:0] cap;
        eff = (ncmd == 0 || ncmd > 8) ? 8 : ncmd;
        next_cyc();
        first_rv = -1; tile_cyc = 0; c = 0;
        start = 1'b1; num_cols = 4'(ncmd); is_pooling_in = pool;
        bus.col_valid = 1'b1; bus.col_desc = rdesc(); bus.res_ready = 1'b0;
        bus.mac_result = 16'($urandom());
        idle_exp();
        k = 0; en_seen = 0; gap_left = gap;
        while (k < eff) begin
            next_cyc(); c++; tile_cyc = c;
            start = 1'b0; is_pooling_in = ~pool;
            v = !(k == 1 && gap_left > 0);
            if (!v) gap_left--;
            bus.col_valid = v; bus.col_desc = rdesc();
            e_col_ready = 1'b1; e_busy = 1'b1; e_pool = pool; e_rv = 1'b0; e_rd = last_res;
            e_en   = v;
            e_ctrl = v ? bus.col_desc : '0;
            e_idx  = v ? IW'(eff - 1 - k) : '0;
            e_msb  = v && (k == 0);
            e_ld   = v && (en_seen == 1);
            if (v) begin k++; en_seen++; end
        end
        // drain
        next_cyc(); c++; tile_cyc = c;
        bus.col_valid = 1'b1; bus.col_desc = rdesc(); bus.mac_result = 16'($urandom());
        e_col_ready = 1'b0; e_en = 1'b1; e_ctrl = '0; e_idx = '0; e_msb = 1'b0;
        e_ld = (en_seen == 1);
        // capture
        next_cyc(); c++; tile_cyc = c;
        cap = 16'($urandom()); bus.mac_result = cap;
        e_en = 1'b0; e_ld = 1'b0;
        // result held until handshake; start pulses here must be ignored
        for (int h = 0; h <= hold; h++) begin
            next_cyc(); c++; tile_cyc = c;
            bus.mac_result = 16'($urandom());
            bus.res_ready = (h == hold);
            start = start_in_done && (h == hold || h == 1);
            last_res = cap; e_rv = 1'b1; e_rd = cap;
        end
        next_cyc(); c++; tile_cyc = c;
        start = 1'b0; bus.res_ready = 1'b0; bus.col_valid = 1'b1;
        idle_exp();
        @(negedge clk); #1;
        chk("latency", 64'(first_rv), 64'(exp_lat));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_cols = 4'd0; is_pooling_in = 1'b0;
        bus.col_valid = 1'b0; bus.col_desc = '0; bus.res_ready = 1'b0; bus.mac_result = '0;
        next_cyc();
        idle_exp(); chk_en = 1'b1;
        next_cyc();
        next_cyc(); reset = 1'b0;

        run_tile(3, 1'b0, 0, 0, 1'b0, 6);
        run_tile(1, 1'b1, 0, 0, 1'b0, 4);
        run_tile(8, 1'b0, 2, 0, 1'b0, 13);
        run_tile(0, 1'b1, 0, 0, 1'b0, 11);
        run_tile(2, 1'b0, 0, 5, 1'b1, 5);

        // Reset after two of four transfers abandons the tile
        next_cyc(); tile_cyc = 0;
        start = 1'b1; num_cols = 4'd4; is_pooling_in = 1'b1; bus.col_valid = 1'b1;
        bus.col_desc = rdesc(); idle_exp();
        for (int k = 0; k < 2; k++) begin
            next_cyc(); tile_cyc = k + 1; start = 1'b0; bus.col_desc = rdesc();
            e_col_ready = 1'b1; e_busy = 1'b1; e_pool = 1'b1; e_rv = 1'b0;
            e_en = 1'b1; e_ctrl = bus.col_desc; e_idx = IW'(3 - k);
            e_msb = (k == 0); e_ld = (k == 1);
        end
        next_cyc(); tile_cyc = 3; reset = 1'b1; bus.col_valid = 1'b0;
        e_en = 1'b0; e_ctrl = '0; e_idx = '0; e_msb = 1'b0; e_ld = 1'b0;
        next_cyc(); tile_cyc = 4; reset = 1'b0; bus.col_valid = 1'b1;
        last_res = 16'd0; idle_exp();
        next_cyc(); tile_cyc = 5; bus.col_valid = 1'b0;

        run_tile(2, 1'b1, 0, 0, 1'b0, 5);
        run_tile(12, 1'b0, 0, 0, 1'b0, 11);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
